conv_mac: RTL and testbench
===========================

# conv_mac

Pipelined 5x5 multiply-accumulate stage that sits directly downstream of the `conv` window generator. It consumes the masked 5x5 kernel stream and applies a runtime-programmable signed coefficient set. It rounds, shifts and clamps the weighted sum, then emits one output pixel per kernel on an AXI-Stream-style master port. Sideband `tuser`/`tlast` travel alongside their kernel through the pipeline.

## Interface
Parameters:
- `PIXEL_W`, 8: unsigned pixel width, for both input taps and the output pixel.
- `COEF_W`, 8: signed coefficient width.
- `SHIFT`, 4: right-shift applied to the accumulated sum; 0 ≤ SHIFT < ACC_W.
- `ACC_W`, PIXEL_W+COEF_W+6: signed accumulator width (derived; do not override).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `s_tvalid_i` in 1: kernel valid.
- `s_tdata_i` in 25*PIXEL_W: kernel taps; tap k = row*5+col, tap 0 = top-left, occupies bits [k*PIXEL_W +: PIXEL_W].
- `s_tuser_i` in 1: start-of-frame sideband.
- `s_tlast_i` in 1: end-of-line sideband.
- `s_tready_o` out 1: kernel accepted when `s_tvalid_i && s_tready_o`.
- `m_tready_i` in 1: downstream ready.
- `m_tvalid_o` out 1: output pixel valid.
- `m_tdata_o` out PIXEL_W: output pixel.
- `m_tuser_o`, `m_tlast_o` out 1: sideband, aligned with `m_tdata_o`.
- `coef_we_i` in 1: coefficient write strobe.
- `coef_addr_i` in 5: tap index 0..24. Writes with address 25..31 are ignored.
- `coef_dat_i` in COEF_W: signed coefficient.
- `sat_o` out 1: sticky saturation flag. Present only with `CONV_MAC_SAT_EN`.

## Operation
- Three pipeline stages, each with a valid bit and sideband:
  - S1: 25 products. Each product is the tap zero-extended to signed, multiplied by its coefficient.
  - S2: five row sums.
  - S3: final sum, then round, shift and clamp, then output register.
- Arithmetic:
  - All sums are signed, sign-extended to ACC_W; the accumulator never overflows.
  - Round half-up: add `1<<(SHIFT-1)` when SHIFT>0, then arithmetic-shift right by SHIFT.
- Global stall: `advance = !m_tvalid_o || m_tready_i`.
  - All stages move together when `advance` is high and hold when it is low.
  - `s_tready_o = advance`.
  - Bubbles are not compressed.
  - A combinational path m_tready_i → s_tready_o exists by design.
- Coefficient bank: 25 registers.
  - Reset value: tap 12 (centre) = `1<<SHIFT`, all others 0. This makes the reset state an identity pass-through.
  - A write on cycle N affects kernels accepted on cycle N+1 onward.
  - A kernel accepted on the same cycle as a write uses the old value. In-flight kernels are unaffected.
  - A write is legal during a stall.
- Ordering: output order equals input order. `tuser`/`tlast` are never reordered or dropped.

## Timing
- Latency: a kernel accepted on cycle N appears on `m_*` at cycle N+3, provided no stall occurs.
- Throughput: 1 kernel/cycle with `m_tready_i` held high.
- Capacity: 3 kernels in flight. With `m_tready_i` low, `s_tready_o` drops immediately (same cycle) once `m_tvalid_o` is high.
- `m_tdata_o`/`m_tuser_o`/`m_tlast_o` are stable while `m_tvalid_o && !m_tready_i`.
- Reset values:
  - `m_tvalid_o`=0 and all stage valids = 0.
  - `m_tdata_o`=0, `m_tuser_o`=0, `m_tlast_o`=0.
  - `sat_o`=0; coefficients at their reset values.
  - `s_tready_o`=1 on the first cycle after reset.
- Reset mid-operation: all in-flight kernels are discarded; `m_tvalid_o` is 0 the cycle after `rst` is sampled high.

## Configuration
- `CONV_MAC_SAT_EN` defined:
  - Shifted result <0 clamps to 0; result >2^PIXEL_W−1 clamps to 2^PIXEL_W−1.
  - `sat_o` sets on any clamped output handshake and clears only on `rst`.
- `CONV_MAC_SAT_EN` undefined:
  - Output is the low PIXEL_W bits of the shifted result (wrap).
  - `sat_o` port is absent.

## Test plan
- Reset coefficients; all taps 7 except centre 200 → `m_tdata_o`=200 exactly 3 cycles after acceptance.
- All coefficients 1, all taps 255, SHIFT=4:
  - The sum 6375 rounds to 398.
  - With SAT_EN → output 255 and `sat_o`=1.
  - Without SAT_EN → output 142.
- Centre coefficient −16, all others 0, centre tap 100 → −100. SAT_EN → output 0, `sat_o`=1. Without → output 156.
- Stream 6 kernels, sideband `tuser` on #0 and `tlast` on #5, with `m_tready_i` low for cycles 2..6:
  - `s_tready_o` falls when the pipeline holds 3 kernels.
  - All 6 outputs arrive in order with sideband intact and stable data during the stall.
- Write centre=32 on the same cycle kernel A is accepted, then send kernel B, both with centre tap 10 → A outputs 10, B outputs 20.
- Assert `rst` with 3 kernels in flight:
  - `m_tvalid_o`=0 the next cycle and no stale output afterwards.
  - The coefficients revert: a post-reset kernel with centre tap 50 outputs 50.

Source files
------------

// File: rtl/conv_mac.sv
// conv_mac: pipelined 5x5 multiply-accumulate stage fed by the conv window
// generator. Each accepted kernel is weighted by a runtime-programmable signed
// coefficient bank. The sum is rounded half-up, arithmetic-shifted right by
// SHIFT and reduced to PIXEL_W bits. One pixel is emitted per kernel, three
// cycles after acceptance.
//
// Optional feature macro: CONV_MAC_SAT_EN
//   defined   : the result is clamped to [0, 2^PIXEL_W-1] and the sticky sat_o
//               port is present.
//   undefined : the result wraps to its low PIXEL_W bits and sat_o is absent.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   s_tvalid_i/s_tready_o           kernel handshake (s_tready_o = advance)
//   s_tdata_i                       25 taps, tap k at [k*PIXEL_W +: PIXEL_W]
//   s_tuser_i/s_tlast_i             start-of-frame / end-of-line sideband
//   m_tvalid_o/m_tready_i           output pixel handshake
//   m_tdata_o/m_tuser_o/m_tlast_o   output pixel and its sideband
//   coef_we_i/coef_addr_i/coef_dat_i  coefficient write port (addr 0..24)
//   sat_o                           sticky clamp flag (CONV_MAC_SAT_EN only)
module conv_mac #(
    parameter int PIXEL_W = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT   = 4,
    parameter int ACC_W   = PIXEL_W + COEF_W + 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid_i,
    input  logic [25*PIXEL_W-1:0]  s_tdata_i,
    input  logic                   s_tuser_i,
    input  logic                   s_tlast_i,
    output logic                   s_tready_o,
    input  logic                   m_tready_i,
    output logic                   m_tvalid_o,
    output logic [PIXEL_W-1:0]     m_tdata_o,
    output logic                   m_tuser_o,
    output logic                   m_tlast_o,
    input  logic                   coef_we_i,
    input  logic [4:0]             coef_addr_i,
    input  logic [COEF_W-1:0]      coef_dat_i
`ifdef CONV_MAC_SAT_EN
    ,
    output logic                   sat_o
`endif
);

    localparam int NTAPS = 25;
    localparam int CENTRE = 12;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] ROUND = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;

    // Global stall: every stage moves together or holds together.
    logic advance;

    logic signed [COEF_W-1:0] coef_q [NTAPS];

    logic signed [ACC_W-1:0] prod_d [NTAPS];
    logic signed [ACC_W-1:0] prod_q [NTAPS];
    logic signed [ACC_W-1:0] row_d  [5];
    logic signed [ACC_W-1:0] row_q  [5];
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] rounded_d;
    logic [PIXEL_W-1:0]      pix_d;

    logic s1_valid_q, s1_user_q, s1_last_q;
    logic s2_valid_q, s2_user_q, s2_last_q;
    logic m_valid_q, m_user_q, m_last_q;
    logic [PIXEL_W-1:0] m_data_q;

`ifdef CONV_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIXEL_W) - 1);
    logic signed [ACC_W-1:0] shifted_d;
    logic clamp_d, clamp_q, sat_q;
`endif

    // The downstream-ready to upstream-ready path is combinational on purpose.
    assign advance    = !m_valid_q || m_tready_i;
    assign s_tready_o = advance;

    // Coefficient bank. A kernel accepted in the same cycle as a write still
    // multiplies by the old value because S1 samples coef_q before it updates.
    // NOTE: the bank is reset explicitly because its reset contents are
    // functional (identity kernel); the datapath registers below need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef_q[k] <= (k == CENTRE) ? COEF_W'(1 << SHIFT) : '0;
            end
        end else if (coef_we_i && (coef_addr_i < 5'd25)) begin
            coef_q[coef_addr_i] <= coef_dat_i;
        end
    end

    // S1 input: each tap is zero-extended and each coefficient sign-extended,
    // so every product is exact in ACC_W bits.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_d[k] = $signed({{(ACC_W-PIXEL_W){1'b0}}, s_tdata_i[k*PIXEL_W +: PIXEL_W]})
                      * $signed({{(ACC_W-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]});
        end
    end

    // S2 input: five row sums of the registered products.
    // NOTE: blocking assignments are used to accumulate inside always_comb,
    // and each row starts from an explicit zero so no latch is inferred.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < 5; c++) begin
                row_d[r] = row_d[r] + prod_q[r*5 + c];
            end
        end
    end

    // S3 input: final sum, half-up rounding, shift, then clamp or wrap.
    always_comb begin
        sum_d = '0;
        for (int r = 0; r < 5; r++) begin
            sum_d = sum_d + row_q[r];
        end
        rounded_d = sum_d + ROUND;
`ifdef CONV_MAC_SAT_EN
        shifted_d = rounded_d >>> SHIFT;
        clamp_d   = 1'b0;
        pix_d     = shifted_d[PIXEL_W-1:0];
        if (shifted_d < 0) begin
            pix_d   = '0;
            clamp_d = 1'b1;
        end else if (shifted_d > PIX_MAX) begin
            pix_d   = '1;
            clamp_d = 1'b1;
        end
`else
        pix_d = PIXEL_W'(rounded_d >>> SHIFT);
`endif
    end

    // Datapath payload registers: only meaningful alongside their valid bit.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < NTAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            for (int r = 0; r < 5; r++) begin
                row_q[r] <= row_d[r];
            end
        end
    end

    // Valid bits, sideband and output register. Bubbles travel with the
    // pipeline rather than being squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_user_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_user_q   <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
`ifdef CONV_MAC_SAT_EN
            clamp_q    <= 1'b0;
`endif
        end else if (advance) begin
            s1_valid_q <= s_tvalid_i;
            s1_user_q  <= s_tvalid_i && s_tuser_i;
            s1_last_q  <= s_tvalid_i && s_tlast_i;
            s2_valid_q <= s1_valid_q;
            s2_user_q  <= s1_user_q;
            s2_last_q  <= s1_last_q;
            m_valid_q  <= s2_valid_q;
            m_user_q   <= s2_user_q;
            m_last_q   <= s2_last_q;
            m_data_q   <= pix_d;
`ifdef CONV_MAC_SAT_EN
            clamp_q    <= clamp_d && s2_valid_q;
`endif
        end
    end

`ifdef CONV_MAC_SAT_EN
    // Sticky: set when a clamped pixel is actually handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (m_valid_q && m_tready_i && clamp_q) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_o = sat_q;
`endif

    assign m_tvalid_o = m_valid_q;
    assign m_tdata_o  = m_data_q;
    assign m_tuser_o  = m_user_q;
    assign m_tlast_o  = m_last_q;

endmodule

// File: tb/tb_conv_mac.sv
// Self-checking bench for conv_mac: expected pixels come from a behavioural
// model of the weighted sum and are queued at acceptance, then compared in
// order as the DUT hands pixels downstream.
module tb_conv_mac;

    localparam int PIXEL_W = 8;
    localparam int COEF_W  = 8;
    localparam int SHIFT   = 4;
    localparam int TW      = 25 * PIXEL_W;
    localparam int PMAX    = (1 << PIXEL_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_tvalid_i;
    logic [TW-1:0]      s_tdata_i;
    logic               s_tuser_i;
    logic               s_tlast_i;
    logic               s_tready_o;
    logic               m_tready_i;
    logic               m_tvalid_o;
    logic [PIXEL_W-1:0] m_tdata_o;
    logic               m_tuser_o;
    logic               m_tlast_o;
    logic               coef_we_i;
    logic [4:0]         coef_addr_i;
    logic [COEF_W-1:0]  coef_dat_i;
`ifdef CONV_MAC_SAT_EN
    logic               sat_o;
`endif

    typedef struct {
        logic [PIXEL_W-1:0] data;
        logic               user;
        logic               last;
    } exp_t;

    exp_t               sb[$];
    logic [PIXEL_W-1:0] obs[$];
    int                 coef_m[25];
    int                 errors = 0;
    int                 checks = 0;

    conv_mac #(.PIXEL_W(PIXEL_W), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid_i (s_tvalid_i),
        .s_tdata_i  (s_tdata_i),
        .s_tuser_i  (s_tuser_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .m_tready_i (m_tready_i),
        .m_tvalid_o (m_tvalid_o),
        .m_tdata_o  (m_tdata_o),
        .m_tuser_o  (m_tuser_o),
        .m_tlast_o  (m_tlast_o),
        .coef_we_i  (coef_we_i),
        .coef_addr_i(coef_addr_i),
        .coef_dat_i (coef_dat_i)
`ifdef CONV_MAC_SAT_EN
        ,
        .sat_o      (sat_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic [PIXEL_W-1:0] model_pix(input logic [TW-1:0] taps);
        int acc;
        int px;
        acc = 0;
        for (int k = 0; k < 25; k++) begin
            px  = int'(taps[k*PIXEL_W +: PIXEL_W]);
            acc = acc + px * coef_m[k];
        end
        if (SHIFT > 0) acc = acc + (1 << (SHIFT - 1));
        acc = acc >>> SHIFT;
`ifdef CONV_MAC_SAT_EN
        if (acc < 0) acc = 0;
        if (acc > PMAX) acc = PMAX;
`endif
        return acc[PIXEL_W-1:0];
    endfunction

    function automatic logic [TW-1:0] fill(input int base, input int centre);
        logic [TW-1:0] t;
        for (int k = 0; k < 25; k++) t[k*PIXEL_W +: PIXEL_W] = base[PIXEL_W-1:0];
        t[12*PIXEL_W +: PIXEL_W] = centre[PIXEL_W-1:0];
        return t;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 25; k++) coef_m[k] = (k == 12) ? (1 << SHIFT) : 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic               stall_seen = 1'b0;
    logic [PIXEL_W-1:0] held_data;
    logic               held_user, held_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                checks++;
                if (m_tvalid_o !== 1'b1 || m_tdata_o !== held_data ||
                    m_tuser_o !== held_user || m_tlast_o !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%0d u=%b l=%b, need v=1 d=%0d u=%b l=%b",
                             m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o,
                             held_data, held_user, held_last);
                end
            end
            if (m_tvalid_o === 1'b1 && m_tready_i === 1'b1) begin
                obs.push_back(m_tdata_o);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got d=%0d with no kernel outstanding", m_tdata_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (m_tdata_o !== e.data || m_tuser_o !== e.user || m_tlast_o !== e.last) begin
                        errors++;
                        $display("FAIL output: got d=%0d u=%b l=%b, need d=%0d u=%b l=%b",
                                 m_tdata_o, m_tuser_o, m_tlast_o, e.data, e.user, e.last);
                    end
                end
            end
            stall_seen = (m_tvalid_o === 1'b1) && (m_tready_i === 1'b0);
            held_data  = m_tdata_o;
            held_user  = m_tuser_o;
            held_last  = m_tlast_o;
        end
    end

    // ---------------- driver tasks (enter/leave just after a posedge) ----------------
    task automatic send(input logic [TW-1:0] taps, input logic user, input logic last);
        int n;
        exp_t e;
        n = 0;
        s_tvalid_i = 1'b1;
        s_tdata_i  = taps;
        s_tuser_i  = user;
        s_tlast_i  = last;
        @(negedge clk);
        while (s_tready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (s_tready_o !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: s_tready_o=%b after %0d cycles, need 1", s_tready_o, n);
            @(posedge clk);
            #1;
            s_tvalid_i = 1'b0;
        end else begin
            e.data = model_pix(taps);
            e.user = user;
            e.last = last;
            sb.push_back(e);
            @(posedge clk);
            #1;
            s_tvalid_i = 1'b0;
            s_tuser_i  = 1'b0;
            s_tlast_i  = 1'b0;
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we_i   = 1'b1;
        coef_addr_i = addr[4:0];
        coef_dat_i  = val[COEF_W-1:0];
        @(posedge clk);
        #1;
        coef_we_i = 1'b0;
        if (addr < 25) coef_m[addr] = val;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs still missing, need 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        checks++;
        if (m_tvalid_o !== 1'b0 || m_tdata_o !== '0 || m_tuser_o !== 1'b0 || m_tlast_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%0d u=%b l=%b, need all 0",
                     m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o);
        end
        checks++;
        if (s_tready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b, need 1", s_tready_o);
        end
`ifdef CONV_MAC_SAT_EN
        checks++;
        if (sat_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: got %b, need 0", sat_o);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_identity_latency();
        logic [TW-1:0] taps;
        exp_t e;
        taps = fill(7, 200);
        obs.delete();
        s_tvalid_i = 1'b1;
        s_tdata_i  = taps;
        @(negedge clk);
        checks++;
        if (s_tready_o !== 1'b1) begin
            errors++;
            $display("FAIL identity_accept: s_tready_o=%b, need 1", s_tready_o);
        end
        e.data = model_pix(taps);
        e.user = 1'b0;
        e.last = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (m_tvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL identity_early: cycle N+%0d m_tvalid_o=%b, need 0", c, m_tvalid_o);
            end
        end
        @(negedge clk);
        checks++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 8'd200) begin
            errors++;
            $display("FAIL identity_latency: cycle N+3 got v=%b d=%0d, need v=1 d=200",
                     m_tvalid_o, m_tdata_o);
        end
        wait_drain("identity");
`ifdef CONV_MAC_SAT_EN
        checks++;
        if (sat_o !== 1'b0) begin
            errors++;
            $display("FAIL identity_sat: got %b, need 0", sat_o);
        end
`endif
    endtask

    task automatic test_coef_update();
        logic [TW-1:0] taps;
        exp_t e;
        taps = fill(0, 10);
        obs.delete();
        // Kernel A accepted in the same cycle as the centre write.
        s_tvalid_i  = 1'b1;
        s_tdata_i   = taps;
        coef_we_i   = 1'b1;
        coef_addr_i = 5'd12;
        coef_dat_i  = 8'd32;
        @(negedge clk);
        checks++;
        if (s_tready_o !== 1'b1) begin
            errors++;
            $display("FAIL coef_accept: s_tready_o=%b, need 1", s_tready_o);
        end
        e.data = model_pix(taps);
        e.user = 1'b0;
        e.last = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        coef_we_i  = 1'b0;
        coef_m[12] = 32;
        send(taps, 1'b0, 1'b0);
        wait_drain("coef");
        checks++;
        if (obs.size() != 2 || obs[0] !== 8'd10 || obs[1] !== 8'd20) begin
            errors++;
            $display("FAIL coef_update: got %0d outputs first=%0d second=%0d, need 2 outputs 10 then 20",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'd0, (obs.size() > 1) ? obs[1] : 8'd0);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [TW-1:0] kern[6];
        int low_cycles;
        for (int k = 0; k < 25; k++) write_coef(k, int'($urandom_range(15)) - 8);
        write_coef(28, 50);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 25; k++) kern[i][k*PIXEL_W +: PIXEL_W] = PIXEL_W'($urandom_range(255));
        end
        obs.delete();
        low_cycles = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(kern[i], i == 0, i == 5);
            end
            begin
                for (int t = 0; t < 14; t++) begin
                    m_tready_i = !(t >= 2 && t <= 6);
                    @(posedge clk);
                    #1;
                end
                m_tready_i = 1'b1;
            end
            begin
                for (int t = 0; t < 14; t++) begin
                    @(negedge clk);
                    checks++;
                    if (s_tready_o !== (!m_tvalid_o || m_tready_i)) begin
                        errors++;
                        $display("FAIL stream_tready: cycle %0d got %b, need %b",
                                 t, s_tready_o, (!m_tvalid_o || m_tready_i));
                    end
                    if (s_tready_o === 1'b0) low_cycles++;
                end
            end
        join
        wait_drain("stream");
        checks++;
        if (obs.size() != 6) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs, need 6", obs.size());
        end
        checks++;
        if (low_cycles == 0) begin
            errors++;
            $display("FAIL stream_backpressure: s_tready_o never fell, need at least one low cycle");
        end
    endtask

    task automatic test_saturation();
        logic [PIXEL_W-1:0] want;
        for (int k = 0; k < 25; k++) write_coef(k, 1);
        write_coef(28, 50);
        obs.delete();
        send(fill(255, 255), 1'b0, 1'b0);
        wait_drain("sat_pos");
`ifdef CONV_MAC_SAT_EN
        want = 8'd255;
        checks++;
        if (sat_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_flag: got %b, need 1", sat_o);
        end
`else
        want = 8'd142;
`endif
        checks++;
        if (obs.size() != 1 || obs[0] !== want) begin
            errors++;
            $display("FAIL sat_pos: got %0d outputs value=%0d, need 1 output %0d",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'd0, want);
        end

        for (int k = 0; k < 25; k++) write_coef(k, (k == 12) ? -16 : 0);
        obs.delete();
        send(fill(0, 100), 1'b0, 1'b0);
        wait_drain("sat_neg");
`ifdef CONV_MAC_SAT_EN
        want = 8'd0;
        checks++;
        if (sat_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_flag: got %b, need 1", sat_o);
        end
`else
        want = 8'd156;
`endif
        checks++;
        if (obs.size() != 1 || obs[0] !== want) begin
            errors++;
            $display("FAIL sat_neg: got %0d outputs value=%0d, need 1 output %0d",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'd0, want);
        end
    endtask

    task automatic test_reset_mid_flight();
        write_coef(12, 64);
        m_tready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(fill(i + 1, 40 + i), i == 0, 1'b0);
        @(negedge clk);
        checks++;
        if (m_tvalid_o !== 1'b1 || s_tready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_full: got v=%b ready=%b, need v=1 ready=0", m_tvalid_o, s_tready_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_tready_i = 1'b1;
        sb.delete();
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
        @(negedge clk);
        checks++;
        if (m_tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b, need 0", m_tvalid_o);
        end
`ifdef CONV_MAC_SAT_EN
        checks++;
        if (sat_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sat: got %b, need 0", sat_o);
        end
`endif
        repeat (6) @(posedge clk);
        #1;
        send(fill(0, 50), 1'b0, 1'b1);
        wait_drain("midreset");
        checks++;
        if (obs.size() != 1 || obs[0] !== 8'd50) begin
            errors++;
            $display("FAIL midreset_revert: got %0d outputs value=%0d, need 1 output 50",
                     obs.size(), (obs.size() > 0) ? obs[0] : 8'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        s_tvalid_i  = 1'b0;
        s_tdata_i   = '0;
        s_tuser_i   = 1'b0;
        s_tlast_i   = 1'b0;
        m_tready_i  = 1'b1;
        coef_we_i   = 1'b0;
        coef_addr_i = '0;
        coef_dat_i  = '0;
        reset_model();
        test_reset();
        test_identity_latency();
        test_coef_update();
        test_back_to_back_stall();
        test_saturation();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
